// File: rtl/aud_player_tx.sv
// I2S DAC transmitter: shifts one PCM sample per LR frame, MSB first with a
// one-BCLK delay, optionally duplicating it onto the right channel.
module aud_player_tx #(
  parameter int DATA_W = 16,
  parameter bit DUP_R  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_ack,
  output logic              o_aud_dacdat,
  output logic              o_busy,
  output logic [15:0]       o_underrun_cnt
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_L,
    S_PAD_L,
    S_SEND_R,
    S_PAD_R
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] hold;
  logic [CW-1:0]     cnt;
  logic              lrck_d;
  logic              primed;
  logic              left_ok;

  logic              fall;
  logic              rise;
  logic [DATA_W-1:0] right_word;

  always_comb begin
    fall       = primed & lrck_d & ~i_daclrck;
    rise       = primed & ~lrck_d & i_daclrck;
    right_word = DUP_R ? hold : '0;
  end

  // LR edges take priority over any shift in progress, so a short half-frame
  // simply truncates the remaining bits and restarts in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      shift          <= '0;
      hold           <= '0;
      cnt            <= '0;
      lrck_d         <= 1'b0;
      primed         <= 1'b0;
      left_ok        <= 1'b0;
      o_ack          <= 1'b0;
      o_aud_dacdat   <= 1'b0;
      o_busy         <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      lrck_d <= i_daclrck;
      primed <= 1'b1;
      o_ack  <= 1'b0;
      if (fall) begin
        if (i_en) begin
          shift        <= i_dac_data << 1;
          hold         <= i_dac_data;
          o_aud_dacdat <= i_dac_data[DATA_W-1];
          cnt          <= CW'(DATA_W - 1);
          o_busy       <= 1'b1;
          o_ack        <= 1'b1;
          left_ok      <= 1'b1;
          state        <= S_SEND_L;
        end else begin
          o_aud_dacdat <= 1'b0;
          o_busy       <= 1'b0;
          left_ok      <= 1'b0;
          state        <= S_PAD_L;
          if (o_underrun_cnt != '1)
            o_underrun_cnt <= o_underrun_cnt + 16'd1;
        end
      end else if (rise) begin
        if (left_ok) begin
          shift        <= right_word << 1;
          o_aud_dacdat <= right_word[DATA_W-1];
          cnt          <= CW'(DATA_W - 1);
          o_busy       <= 1'b1;
          state        <= S_SEND_R;
        end else begin
          o_aud_dacdat <= 1'b0;
          o_busy       <= 1'b0;
          state        <= S_PAD_R;
        end
      end else begin
        case (state)
          S_SEND_L, S_SEND_R: begin
            if (cnt == '0) begin
              o_aud_dacdat <= 1'b0;
              o_busy       <= 1'b0;
              state        <= (state == S_SEND_L) ? S_PAD_L : S_PAD_R;
            end else begin
              o_aud_dacdat <= shift[DATA_W-1];
              shift        <= shift << 1;
              cnt          <= cnt - CW'(1);
            end
          end
          default: begin
            o_aud_dacdat <= 1'b0;
            o_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_player_tx.sv
// Directed bench for aud_player_tx: table of LR frames plus hand-written
// reset-mid-shift sequence; one instance per right-channel mode.
module tb_aud_player_tx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         lrck;
  logic         en;
  logic [W-1:0] data;

  logic         ack, dat, busy;
  logic [15:0]  ucnt;
  logic         ack0, dat0, busy0;
  logic [15:0]  ucnt0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aud_player_tx #(.DATA_W(W), .DUP_R(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_daclrck(lrck), .i_en(en), .i_dac_data(data),
    .o_ack(ack), .o_aud_dacdat(dat), .o_busy(busy), .o_underrun_cnt(ucnt)
  );

  aud_player_tx #(.DATA_W(W), .DUP_R(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_daclrck(lrck), .i_en(en), .i_dac_data(data),
    .o_ack(ack0), .o_aud_dacdat(dat0), .o_busy(busy0), .o_underrun_cnt(ucnt0)
  );

  typedef struct {
    int          half;
    logic        en;
    logic [15:0] data;
    int          exp_acks;
    logic [15:0] exp_ucnt;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected serial stream for one half-frame: sample i holds bit 15-i,
  // zeros once the word is exhausted or the half-frame ends.
  function automatic logic [63:0] exp_bits(input logic [15:0] w, input int half);
    logic [63:0] e = '0;
    for (int i = 0; i < half && i < W; i++) e[i] = w[W-1-i];
    return e;
  endfunction

  function automatic logic [63:0] exp_busy(input int half);
    logic [63:0] e = '0;
    for (int i = 0; i < half && i < W; i++) e[i] = 1'b1;
    return e;
  endfunction

  task automatic run_half(input logic lvl, input int half,
                          output logic [63:0] b, output logic [63:0] b0,
                          output logic [63:0] bz, output int acks, output int acks0);
    b = '0; b0 = '0; bz = '0; acks = 0; acks0 = 0;
    for (int i = 0; i < half; i++) begin
      @(negedge clk);
      lrck = lvl;
      @(posedge clk);
      #1;
      b[i]  = dat;
      b0[i] = dat0;
      bz[i] = busy;
      acks  += int'(ack);
      acks0 += int'(ack0);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [63:0] bl, bl0, bzl, br, br0, bzr;
    int al, al0, ar, ar0;
    logic [63:0] el, eb;

    vecs[0]  = '{30, 1'b1, 16'hA5A5, 1, 16'd0};
    vecs[1]  = '{30, 1'b1, 16'h8001, 1, 16'd0};
    vecs[2]  = '{30, 1'b0, 16'h0000, 0, 16'd1};
    vecs[3]  = '{30, 1'b0, 16'hFFFF, 0, 16'd2};
    vecs[4]  = '{30, 1'b0, 16'h5555, 0, 16'd3};
    vecs[5]  = '{10, 1'b1, 16'h1234, 1, 16'd3};
    vecs[6]  = '{10, 1'b1, 16'hABCD, 1, 16'd3};
    vecs[7]  = '{20, 1'b1, 16'h0001, 1, 16'd3};
    vecs[8]  = '{20, 1'b1, 16'h0002, 1, 16'd3};
    vecs[9]  = '{20, 1'b1, 16'h0003, 1, 16'd3};
    vecs[10] = '{20, 1'b1, 16'h0004, 1, 16'd3};
    vecs[11] = '{20, 1'b1, 16'h0005, 1, 16'd3};

    rst = 1'b1; lrck = 1'b1; en = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {47'd0, ack, dat, busy, ucnt}, '0);
    check("reset outputs dup0", {47'd0, ack0, dat0, busy0, ucnt0}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[k]) begin
      en   = vecs[k].en;
      data = vecs[k].data;
      run_half(1'b0, vecs[k].half, bl, bl0, bzl, al, al0);
      run_half(1'b1, vecs[k].half, br, br0, bzr, ar, ar0);
      el = vecs[k].en ? exp_bits(vecs[k].data, vecs[k].half) : '0;
      eb = vecs[k].en ? exp_busy(vecs[k].half) : '0;
      check($sformatf("v%0d left", k), bl, el);
      check($sformatf("v%0d right", k), br, el);
      check($sformatf("v%0d left dup0", k), bl0, el);
      check($sformatf("v%0d right dup0", k), br0, '0);
      check($sformatf("v%0d busy left", k), bzl, eb);
      check($sformatf("v%0d busy right", k), bzr, eb);
      check($sformatf("v%0d acks", k), 64'(al + ar), 64'(vecs[k].exp_acks));
      check($sformatf("v%0d acks dup0", k), 64'(al0 + ar0), 64'(vecs[k].exp_acks));
      check($sformatf("v%0d underrun", k), 64'(ucnt), 64'(vecs[k].exp_ucnt));
      check($sformatf("v%0d underrun dup0", k), 64'(ucnt0), 64'(vecs[k].exp_ucnt));
    end

    // Reset while bit 7 of an all-ones word is on the line.
    en = 1'b1;
    data = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      lrck = 1'b0;
      @(posedge clk);
      #1;
    end
    check("pre-reset bit7", 64'(dat), 64'd1);
    rst = 1'b1;
    #1;
    check("reset mid-shift dat", 64'({dat, dat0}), 64'd0);
    check("reset mid-shift busy", 64'({busy, busy0}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_half(1'b0, 10, bl, bl0, bzl, al, al0);
    run_half(1'b1, 30, br, br0, bzr, ar, ar0);
    check("post-reset quiet left", bl | bl0 | bzl, '0);
    check("post-reset quiet right", br | br0 | bzr, '0);
    check("post-reset no ack", 64'(al + ar + al0 + ar0), 64'd0);
    check("post-reset underrun", 64'(ucnt), 64'd0);
    data = 16'hC3A1;
    run_half(1'b0, 30, bl, bl0, bzl, al, al0);
    run_half(1'b1, 30, br, br0, bzr, ar, ar0);
    check("resume left", bl, exp_bits(16'hC3A1, 30));
    check("resume right", br, exp_bits(16'hC3A1, 30));
    check("resume right dup0", br0, '0);
    check("resume acks", 64'(al + ar), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/aud_player_tx.md
AUD_PLAYER_TX -- requirements
Module: aud_player_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits.
REQ-002 SHALL have parameter DUP_R, default 1: 1 sends the left sample again on the right channel; 0 sends zeros on the right channel.
REQ-003 SHALL have port i_clk, input, 1 bit: the I2S bit clock, which is the sole clock.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_daclrck, input, 1 bit: the DAC LR clock (low = left, high = right), synchronous to i_clk.
REQ-006 SHALL have port i_en, input, 1 bit: sample-valid request from the DSP.
REQ-007 SHALL have port i_dac_data, input, DATA_W bits: signed PCM sample, stable while i_en is high.
REQ-008 SHALL have port o_ack, output, 1 bit: one-cycle pulse when the sample is consumed.
REQ-009 SHALL have port o_aud_dacdat, output, 1 bit: serial I2S data, MSB first.
REQ-010 SHALL have port o_busy, output, 1 bit: high while bits are shifting.
REQ-011 SHALL have port o_underrun_cnt, output, 16 bits: saturating count of left frames with no sample available.

Function
REQ-012 SHALL register all outputs; there is no combinational path from input to output.
REQ-013 SHALL keep a registered copy lrck_d and a primed flag; no edge is detected in the first cycle after reset release.
REQ-014 SHALL detect a falling edge (left start) in cycle t when primed, lrck_d = 1 and i_daclrck = 0; a rising edge (right start) is the converse.
REQ-015 SHALL implement the states S_IDLE, S_SEND_L, S_PAD_L, S_SEND_R and S_PAD_R, with reset state S_IDLE.
REQ-016 SHALL, on a falling edge at cycle t with i_en = 1 in any state, latch i_dac_data into the shift and hold registers, assert o_ack in cycle t+1 only, and enter S_SEND_L.
REQ-017 SHALL, on a falling edge with i_en = 0, increment o_underrun_cnt (saturating at 16'hFFFF), not assert o_ack, and enter S_PAD_L with output 0.
REQ-018 SHALL, in S_SEND_x, drive o_aud_dacdat with bits DATA_W-1 down to 0 on cycles t+1 through t+DATA_W (one-BCLK I2S delay), then enter S_PAD_x.
REQ-019 SHALL drive o_aud_dacdat = 0 and o_busy = 0 in S_PAD_x and in S_IDLE; o_busy = 1 in S_SEND_x.
REQ-020 SHALL, on a rising edge after a valid left sample, enter S_SEND_R and shift out the hold register when DUP_R = 1, or zeros when DUP_R = 0.
REQ-021 SHALL, on a rising edge after an underrun left frame, enter S_PAD_R with output 0.
REQ-022 SHALL, on an LR edge arriving mid-shift (half-frame shorter than DATA_W cycles), abort the remaining bits and process the new edge in that same cycle per REQ-016 to REQ-021.
REQ-023 SHALL ignore i_en outside falling-edge cycles; i_en held high produces at most one o_ack per LR frame.
REQ-024 SHALL treat i_en and a falling edge in the same cycle as a valid sample; no extra setup cycle is required.

Reset
REQ-025 SHALL force, while i_rst = 1: S_IDLE, o_ack = 0, o_aud_dacdat = 0, o_busy = 0, o_underrun_cnt = 0, shift and hold registers = 0, primed = 0, lrck_d = 0.
REQ-026 SHALL, on assertion of i_rst mid-shift, drop o_aud_dacdat to 0 immediately, and SHALL resume only on the next LR edge after re-priming.

Verification
REQ-027 SHALL be verified with a 30-cycle-low / 30-cycle-high LRCK, i_en = 1 and i_dac_data = 16'hA5A5 -> 1010010110100101 on o_aud_dacdat from 1 cycle after the falling edge, o_ack pulsed once, and the same 16 bits after the rising edge.
REQ-028 SHALL be verified with DUP_R = 0 and i_dac_data = 16'h8001 -> left bits 1000000000000001, right half all 0.
REQ-029 SHALL be verified with i_en = 0 across 3 frames -> no o_ack, o_aud_dacdat constant 0, o_underrun_cnt = 3.
REQ-030 SHALL be verified with a 10-cycle LRCK half-period and DATA_W = 16 -> only 10 MSBs sent per half, the next frame starting cleanly, and o_ack once per frame.
REQ-031 SHALL be verified by asserting i_rst at bit 7 of a shift -> o_aud_dacdat = 0 in the same time step and no output until the second LR edge after release.
REQ-032 SHALL be verified with i_en held high for 5 frames at values 1, 2, 3, 4, 5 -> exactly 5 o_ack pulses, each emitted sample equal to the value present at its falling edge.
